alu_pipe_datapath: RTL and testbench
====================================

Name: alu_pipe_datapath

Overview:
Two-stage pipelined register-file/ALU datapath. Parametrised next generation of the single-cycle register file + operand mux + ALU top.
- Adds an 8-operation ALU, a registered execute result, delayed writeback with an x0-hardwired register file, operand forwarding, and valid tracking.
- Sits between decode/control (which drives addresses, immediate and ALUctrl) and branch logic (which consumes EQ).

Parameters:
REG_FILE_ADDR_WIDTH, 5, register address width; register count = 2**REG_FILE_ADDR_WIDTH
DATA_WIDTH, 32, operand/result width (power of two, >= 8)
ALU_CTRL_WIDTH, 3, ALU operation select width
A0_ADDR, 10, register index mirrored on a0

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented this cycle
ALUsrc  input  1  0: op2 = RD2; 1: op2 = ImmOp
ALUctrl  input  ALU_CTRL_WIDTH  operation select
AD1  input  REG_FILE_ADDR_WIDTH  source register 1
AD2  input  REG_FILE_ADDR_WIDTH  source register 2
AD3  input  REG_FILE_ADDR_WIDTH  destination register
WE3  input  1  write-enable for destination
ImmOp  input  DATA_WIDTH  signed immediate
out_valid  output  1  ALUout/EQ hold a valid result
ALUout  output  DATA_WIDTH  registered ALU result
EQ  output  1  registered (op1 == op2)
a0  output  DATA_WIDTH  current contents of register A0_ADDR

Behaviour:
- Reset (rst_n low, asynchronous):
  - All register-file entries = 0.
  - Pipeline register cleared: out_valid=0, ALUout=0, EQ=0, wb_we=0.
  - a0=0.
  - A pending writeback is discarded, not completed.
- Stage EX (combinational within cycle N):
  - RD1/RD2 read from the register file; register 0 always reads 0.
  - Forwarding: if wb_valid & wb_we & wb_ad3!=0 & wb_ad3==AD1, op1 = ALUout (pipeline register); same rule applies to AD2 for RD2.
  - op2 = ALUsrc ? ImmOp : forwarded RD2.
- ALUctrl encoding. Wrap-around modulo 2**DATA_WIDTH; no overflow flag.
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed, result 1 or 0, zero-extended
  - 110 SLL by op2[$clog2(DATA_WIDTH)-1:0]
  - 111 SRA (arithmetic) by the same field
- Pipeline register (edge end of N):
  - out_valid <= in_valid.
  - If in_valid: ALUout <= result, EQ <= (op1==op2), wb_ad3 <= AD3, wb_we <= WE3.
  - If !in_valid: ALUout and EQ hold their values; wb_we <= 0.
- Stage WB (edge end of N+1): if out_valid & wb_we & wb_ad3!=0, regfile[wb_ad3] <= ALUout.
- Latency: result visible on ALUout 1 cycle after issue; architecturally written 2 cycles after issue.
- Back-to-back dependent ops need no stall: the forward path covers the only in-flight write. Older writes are already in the register file.
- Writes to register 0 are suppressed and never forwarded.
- Same-edge write and read: the register file is written on the edge. A read in the same cycle gets the forwarded value, so no write-through is required in the register file itself.
- a0 reflects register A0_ADDR after writeback (register-file output, not forwarded).
- EQ is meaningful only when out_valid=1.

Decomposition:
- Package alu_pipe_pkg holds:
  - enum alu_op_t (ALU_ADD..ALU_SRA) with the encodings above;
  - a localparam for the shift-amount width.
- Sub-module alu_core: purely combinational. Inputs op1, op2, alu_op_t; outputs result, eq. Parametrised on DATA_WIDTH.
- Register file, forwarding muxes and pipeline register are coded in the top.

Test Plan:
- Reset: assert rst_n=0 mid-stream after issuing ADDI x5 = 7 -> out_valid=0, ALUout=0, a0=0; a read of x5 after release returns 0.
- Immediate chain with forwarding: ADDI x10=x0+5 then, next cycle, ADDI x10=x10+3 -> ALUout=5, then 8; a0=5 two cycles after first issue, a0=8 one cycle later.
- Register-sourced forward on op2: x1=12, x2=12 (ALUsrc=1), then SUB x3=x1-x2 issued immediately after x2 -> ALUout=0, EQ=1; then SUB with x2=13 -> ALUout=0xFFFFFFFF, EQ=0.
- Ops sweep: op1=0x80000000, imm=4 -> SLL=0, SRA=0xF8000000, SLT(op1<4)=1, XOR=0x80000004; imm=0x21 for SLL shifts by 1 -> 0.
- x0 protection: ADDI x0=x0+9 followed by ADD x4=x0+x0 -> x4=0, no forward taken.
- Bubble: in_valid=0 between dependent ops -> out_valid drops for one cycle, ALUout holds, no spurious write (wb_we=0); the dependent op reads the committed value from the register file.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined register-file/ALU datapath:
// ALU operation encodings and the helpers that size the shift amount.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int SHAMT_WIDTH        = $clog2(DEFAULT_DATA_WIDTH);

  function automatic int shamtWidth(input int dataWidth);
    return $clog2(dataWidth);
  endfunction

endpackage

// File: rtl/alu_pipe_datapath_alu_core.sv
// Purely combinational 8-operation ALU with an operand-equality flag.
// Arithmetic wraps modulo 2**DATA_WIDTH; shifts use the low log2(DATA_WIDTH) bits of op2.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  alu_op_t               op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  eq_o
);

  localparam int ShW = shamtWidth(DATA_WIDTH);

  logic [ShW-1:0] shamt;
  logic           lessSigned;

  assign shamt      = op2_i[ShW-1:0];
  assign lessSigned = $signed(op1_i) < $signed(op2_i);
  assign eq_o       = (op1_i == op2_i);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_ADD: result_o = op1_i + op2_i;
      ALU_SUB: result_o = op1_i - op2_i;
      ALU_AND: result_o = op1_i & op2_i;
      ALU_OR:  result_o = op1_i | op2_i;
      ALU_XOR: result_o = op1_i ^ op2_i;
      ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, lessSigned};
      ALU_SLL: result_o = op1_i << shamt;
      ALU_SRA: result_o = DATA_WIDTH'($signed(op1_i) >>> shamt);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_datapath.sv
// Two-stage register-file/ALU datapath: EX computes into a pipeline register,
// WB commits it one edge later; the single in-flight result is forwarded to EX.
module alu_pipe_datapath
  import alu_pipe_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int ALU_CTRL_WIDTH      = 3,
  parameter int A0_ADDR             = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           ALUsrc,
  input  logic [ALU_CTRL_WIDTH-1:0]      ALUctrl,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  input  logic                           WE3,
  input  logic [DATA_WIDTH-1:0]          ImmOp,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          ALUout,
  output logic                           EQ,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int NumRegs = 2 ** REG_FILE_ADDR_WIDTH;
  localparam logic [REG_FILE_ADDR_WIDTH-1:0] A0Idx = REG_FILE_ADDR_WIDTH'(A0_ADDR);

  logic [DATA_WIDTH-1:0]          rf_q [NumRegs];

  logic                           out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]          alu_out_q, alu_out_d;
  logic                           eq_q, eq_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_ad3_q, wb_ad3_d;
  logic                           wb_we_q, wb_we_d;

  logic [DATA_WIDTH-1:0]          rd1, rd2, op1, op2;
  logic [DATA_WIDTH-1:0]          aluResult;
  logic                           aluEq;
  logic                           wbFire, fwd1, fwd2;
  alu_op_t                        aluOp;

  // A committed write needs a live, enabled result aimed at a non-zero register.
  assign wbFire = out_valid_q && wb_we_q && (wb_ad3_q != '0);
  assign fwd1   = wbFire && (wb_ad3_q == AD1);
  assign fwd2   = wbFire && (wb_ad3_q == AD2);

  always_comb begin
    rd1 = (AD1 == '0) ? '0 : rf_q[AD1];
    rd2 = (AD2 == '0) ? '0 : rf_q[AD2];
    op1 = fwd1 ? alu_out_q : rd1;
    op2 = ALUsrc ? ImmOp : (fwd2 ? alu_out_q : rd2);
  end

  assign aluOp = alu_op_t'(ALUctrl[2:0]);

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_core (
    .op1_i   (op1),
    .op2_i   (op2),
    .op_i    (aluOp),
    .result_o(aluResult),
    .eq_o    (aluEq)
  );

  // Bubbles keep ALUout/EQ stable but must never leave a write armed.
  always_comb begin
    out_valid_d = in_valid;
    alu_out_d   = alu_out_q;
    eq_d        = eq_q;
    wb_ad3_d    = wb_ad3_q;
    wb_we_d     = 1'b0;
    if (in_valid) begin
      alu_out_d = aluResult;
      eq_d      = aluEq;
      wb_ad3_d  = AD3;
      wb_we_d   = WE3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      eq_q        <= 1'b0;
      wb_ad3_q    <= '0;
      wb_we_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      eq_q        <= eq_d;
      wb_ad3_q    <= wb_ad3_d;
      wb_we_q     <= wb_we_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wbFire) begin
      rf_q[wb_ad3_q] <= alu_out_q;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUout    = alu_out_q;
  assign EQ        = eq_q;
  assign a0        = rf_q[A0Idx];

endmodule

// File: tb/tb_alu_pipe_datapath.sv
// Directed scoreboard bench for alu_pipe_datapath: each issued op pushes its
// expected ALUout/EQ, which is popped and compared one edge later.
module tb_alu_pipe_datapath;

  typedef struct {
    logic [31:0] alu;
    logic        eq;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3;
  logic [31:0] ImmOp;
  logic        out_valid;
  logic [31:0] ALUout;
  logic        EQ;
  logic [31:0] a0;

  exp_t        sbQ[$];
  logic [31:0] lastAlu;
  logic        lastEq;
  int          checks;
  int          failures;

  alu_pipe_datapath #(
    .REG_FILE_ADDR_WIDTH(5),
    .DATA_WIDTH         (32),
    .ALU_CTRL_WIDTH     (3),
    .A0_ADDR            (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .ALUsrc   (ALUsrc),
    .ALUctrl  (ALUctrl),
    .AD1      (AD1),
    .AD2      (AD2),
    .AD3      (AD3),
    .WE3      (WE3),
    .ImmOp    (ImmOp),
    .out_valid(out_valid),
    .ALUout   (ALUout),
    .EQ       (EQ),
    .a0       (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, got, want);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  // Pops the scoreboard when an op was issued; otherwise the outputs must hold.
  task automatic checkOutput(input string tag, input bit issued);
    exp_t e;
    checkBit({tag, ".out_valid"}, out_valid, issued);
    if (issued) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else begin
        e = sbQ.pop_front();
        checkWord({tag, ".ALUout"}, ALUout, e.alu);
        checkBit({tag, ".EQ"}, EQ, e.eq);
        lastAlu = e.alu;
        lastEq  = e.eq;
      end
    end else begin
      checkWord({tag, ".ALUout_hold"}, ALUout, lastAlu);
      checkBit({tag, ".EQ_hold"}, EQ, lastEq);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit valid, input bit src,
                               input logic [2:0] ctrl, input logic [4:0] ad1,
                               input logic [4:0] ad2, input logic [4:0] ad3,
                               input bit we, input logic [31:0] imm,
                               input logic [31:0] expAlu, input logic expEq);
    exp_t e;
    @(negedge clk);
    in_valid = valid;
    ALUsrc   = src;
    ALUctrl  = ctrl;
    AD1      = ad1;
    AD2      = ad2;
    AD3      = ad3;
    WE3      = we;
    ImmOp    = imm;
    if (valid) begin
      e.alu = expAlu;
      e.eq  = expEq;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput(tag, valid);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lastAlu  = 32'h0;
    lastEq   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUsrc   = 1'b0;
    ALUctrl  = 3'b000;
    AD1      = '0;
    AD2      = '0;
    AD3      = '0;
    WE3      = 1'b0;
    ImmOp    = '0;

    repeat (2) @(negedge clk);
    checkBit("rst.out_valid", out_valid, 1'b0);
    checkWord("rst.ALUout", ALUout, 32'h0);
    checkBit("rst.EQ", EQ, 1'b0);
    checkWord("rst.a0", a0, 32'h0);
    rst_n = 1'b1;

    // Mid-stream reset discards the pending write of x5.
    applyStimulus("addi_x5", 1, 1, 3'b000, 5'd0, 5'd0, 5'd5, 1, 32'd7, 32'd7, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkBit("midrst.out_valid", out_valid, 1'b0);
    checkWord("midrst.ALUout", ALUout, 32'h0);
    checkWord("midrst.a0", a0, 32'h0);
    sbQ.delete();
    lastAlu = 32'h0;
    lastEq  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("read_x5", 1, 0, 3'b000, 5'd5, 5'd0, 5'd6, 1, 32'd0, 32'd0, 1'b1);

    // Immediate chain through x10 (mirrored on a0) with forwarding.
    applyStimulus("addi_x10_5", 1, 1, 3'b000, 5'd0, 5'd0, 5'd10, 1, 32'd5, 32'd5, 1'b0);
    applyStimulus("addi_x10_p3", 1, 1, 3'b000, 5'd10, 5'd0, 5'd10, 1, 32'd3, 32'd8, 1'b0);
    checkWord("chain.a0_first", a0, 32'd5);
    applyStimulus("bubble_a0", 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 1'b0);
    checkWord("chain.a0_second", a0, 32'd8);

    // Register-sourced forward on op2.
    applyStimulus("addi_x1", 1, 1, 3'b000, 5'd0, 5'd0, 5'd1, 1, 32'd12, 32'd12, 1'b0);
    applyStimulus("addi_x2", 1, 1, 3'b000, 5'd0, 5'd0, 5'd2, 1, 32'd12, 32'd12, 1'b0);
    applyStimulus("sub_eq", 1, 0, 3'b001, 5'd1, 5'd2, 5'd3, 1, 32'd0, 32'd0, 1'b1);
    applyStimulus("addi_x2_13", 1, 1, 3'b000, 5'd0, 5'd0, 5'd2, 1, 32'd13, 32'd13, 1'b0);
    applyStimulus("sub_neg", 1, 0, 3'b001, 5'd1, 5'd2, 5'd3, 1, 32'd0, 32'hFFFF_FFFF, 1'b0);

    // Operation sweep with op1 = 0x80000000 in x7.
    applyStimulus("addi_x7", 1, 1, 3'b000, 5'd0, 5'd0, 5'd7, 1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("sll4", 1, 1, 3'b110, 5'd7, 5'd0, 5'd0, 0, 32'd4, 32'h0000_0000, 1'b0);
    applyStimulus("sra4", 1, 1, 3'b111, 5'd7, 5'd0, 5'd0, 0, 32'd4, 32'hF800_0000, 1'b0);
    applyStimulus("slt4", 1, 1, 3'b101, 5'd7, 5'd0, 5'd0, 0, 32'd4, 32'h0000_0001, 1'b0);
    applyStimulus("xor4", 1, 1, 3'b100, 5'd7, 5'd0, 5'd0, 0, 32'd4, 32'h8000_0004, 1'b0);
    applyStimulus("sll_wrap", 1, 1, 3'b110, 5'd7, 5'd0, 5'd0, 0, 32'h21, 32'h0000_0000, 1'b0);
    applyStimulus("and", 1, 1, 3'b010, 5'd7, 5'd0, 5'd0, 0, 32'h8000_0001, 32'h8000_0000, 1'b0);
    applyStimulus("or", 1, 1, 3'b011, 5'd7, 5'd0, 5'd0, 0, 32'h0000_0001, 32'h8000_0001, 1'b0);
    applyStimulus("add_wrap", 1, 1, 3'b000, 5'd7, 5'd0, 5'd0, 0, 32'h8000_0000, 32'h0000_0000, 1'b1);

    // x0 is never written nor forwarded.
    applyStimulus("addi_x0", 1, 1, 3'b000, 5'd0, 5'd0, 5'd0, 1, 32'd9, 32'd9, 1'b0);
    applyStimulus("add_x4", 1, 0, 3'b000, 5'd0, 5'd0, 5'd4, 1, 32'd0, 32'd0, 1'b1);
    applyStimulus("addi_x9", 1, 1, 3'b000, 5'd4, 5'd0, 5'd9, 1, 32'd1, 32'd1, 1'b0);

    // Bubble between dependent ops; the bubble's WE3/AD3 must not write a0.
    applyStimulus("addi_x11", 1, 1, 3'b000, 5'd0, 5'd0, 5'd11, 1, 32'd20, 32'd20, 1'b0);
    applyStimulus("bubble", 0, 1, 3'b000, 5'd0, 5'd0, 5'd10, 1, 32'd99, 32'd0, 1'b0);
    applyStimulus("addi_x12", 1, 1, 3'b000, 5'd11, 5'd0, 5'd12, 1, 32'd1, 32'd21, 1'b0);
    applyStimulus("idle", 0, 0, 3'b000, 5'd0, 5'd0, 5'd10, 1, 32'd0, 32'd0, 1'b0);
    checkWord("bubble.a0", a0, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
